l1_readout_tracker: RTL and testbench

//  Read-side partner of the L1 trigger-in counter. Receives the Gray-coded, TMR-voted write count L1In,

---
 rtl/l1_readout_tracker.sv | 171 +++++++++++++++++
 tb/tb_l1_readout_tracker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_readout_tracker.sv
// l1_readout_tracker: read side of the L1 trigger-in counter.
// Decodes the Gray write count, keeps a TMR read pointer, offers pending
// triggers over a valid/ack/done handshake and throttles the write side.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing pending, Trig_Valid low
// OFFER  | trigger rd_bin+1 offered, Trig_Valid high, waiting for Ack
// BUSY   | trigger accepted, readout running, waiting for Read_Done
module l1_readout_tracker #(
    parameter int CNT_W      = 4,
    parameter int FULL_LEVEL = 13
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] i_L1In,
    input  logic             i_Trig_Ack,
    input  logic             i_Read_Done,
    output logic             o_Trig_Valid,
    output logic [CNT_W-1:0] o_Trig_Id,
    output logic [CNT_W-1:0] o_Pending,
    output logic             o_L1_Reg_Full,
    output logic             o_Error,
    output logic             o_Seq_Error
);

    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FULL_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] f_gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b[CNT_W-1] = g[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_l1in_q;
    logic [CNT_W-1:0] r_rd0;
    logic [CNT_W-1:0] r_rd1;
    logic [CNT_W-1:0] r_rd2;
    logic [CNT_W-1:0] r_trig_id;
    logic [CNT_W-1:0] r_pending;
    logic             r_full;
    logic             r_seq_err;
    logic [2:0]       r_err;

    logic [CNT_W-1:0] w_wr_bin;
    logic [CNT_W-1:0] w_rd_bin;
    logic [CNT_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_pend_cur;
    logic [CNT_W-1:0] w_pend_in;
    logic [CNT_W-1:0] w_gray_diff;
    logic [CNT_W-1:0] w_trig_id_nxt;
    logic             w_done_ok;
    logic             w_gray_bad;
    logic             w_pend_drop;
    logic             w_seq_set;
    logic             w_rd_mis;

    assign w_wr_bin   = f_gray2bin(r_l1in_q);
    assign w_rd_bin   = (r_rd0 & r_rd1) | (r_rd0 & r_rd2) | (r_rd1 & r_rd2);
    assign w_pend_cur = w_wr_bin - w_rd_bin;
    assign w_rd_nxt   = w_done_ok ? (w_rd_bin + ONE_C) : w_rd_bin;

    // The incoming sample is checked against the held one, so a bad step is
    // flagged on the same edge that captures it.
    assign w_gray_diff = i_L1In ^ r_l1in_q;
    assign w_gray_bad  = (w_gray_diff & (w_gray_diff - ONE_C)) != '0;
    assign w_pend_in   = f_gray2bin(i_L1In) - w_rd_bin;
    assign w_pend_drop = w_pend_in < w_pend_cur;
    assign w_seq_set   = (i_Read_Done && (r_state != ST_BUSY)) || w_gray_bad || w_pend_drop;

    assign w_rd_mis = (r_rd0 != r_rd1) || (r_rd0 != r_rd2);

    // Input stage, voted read pointer copies and registered status
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_l1in_q  <= '0;
            r_rd0     <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_pending <= '0;
            r_full    <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_l1in_q  <= i_L1In;
            r_rd0     <= w_rd_nxt;
            r_rd1     <= w_rd_nxt;
            r_rd2     <= w_rd_nxt;
            r_pending <= w_pend_cur;
            r_full    <= (w_pend_cur >= FULL_C);
            if (w_seq_set) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    // FSM state and offered trigger id
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_trig_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_trig_id <= w_trig_id_nxt;
        end
    end

    // FSM next state; decisions use the live pointer difference because the
    // registered Pending still shows the pre-done value for one cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_trig_id_nxt = r_trig_id;
        w_done_ok     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_cur != '0) begin
                    w_state_nxt   = ST_OFFER;
                    w_trig_id_nxt = w_rd_bin + ONE_C;
                end
            end
            ST_OFFER: begin
                if (i_Trig_Ack) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_Read_Done) begin
                    w_done_ok = 1'b1;
                    if (w_pend_cur != ONE_C) begin
                        w_state_nxt   = ST_OFFER;
                        w_trig_id_nxt = w_rd_bin + TWO_C;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pointer disagreement sampled mid-cycle into three voted flops
    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err <= '0;
        end else begin
            r_err <= {3{w_rd_mis}};
        end
    end

    assign o_Trig_Valid  = (r_state == ST_OFFER);
    assign o_Trig_Id     = r_trig_id;
    assign o_Pending     = r_pending;
    assign o_L1_Reg_Full = r_full;
    assign o_Error       = (r_err[0] & r_err[1]) | (r_err[0] & r_err[2]) | (r_err[1] & r_err[2]);
    assign o_Seq_Error   = r_seq_err;

endmodule

// File: tb/tb_l1_readout_tracker.sv
// Directed bench for l1_readout_tracker: reset state, single trigger,
// full throttle, pointer wrap, TMR upset and sequence errors.
module tb_l1_readout_tracker;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [3:0] i_L1In = '0;
    logic       i_Trig_Ack = 1'b0;
    logic       i_Read_Done = 1'b0;
    logic       o_Trig_Valid;
    logic [3:0] o_Trig_Id;
    logic [3:0] o_Pending;
    logic       o_L1_Reg_Full;
    logic       o_Error;
    logic       o_Seq_Error;

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] wr_cnt = '0;

    l1_readout_tracker #(.CNT_W(4), .FULL_LEVEL(13)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_L1In       (i_L1In),
        .i_Trig_Ack   (i_Trig_Ack),
        .i_Read_Done  (i_Read_Done),
        .o_Trig_Valid (o_Trig_Valid),
        .o_Trig_Id    (o_Trig_Id),
        .o_Pending    (o_Pending),
        .o_L1_Reg_Full(o_L1_Reg_Full),
        .o_Error      (o_Error),
        .o_Seq_Error  (o_Seq_Error)
    );

    // 10 ns clock
    always #5 Clk = ~Clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge Clk);
            #1;
        end
    endtask

    task automatic l1_inc();
        wr_cnt = wr_cnt + 4'd1;
        i_L1In = wr_cnt ^ (wr_cnt >> 1);
    endtask

    task automatic do_reset();
        Reset       = 1'b0;
        wr_cnt      = '0;
        i_L1In      = '0;
        i_Trig_Ack  = 1'b0;
        i_Read_Done = 1'b0;
        cyc(2);
        Reset = 1'b1;
        cyc(1);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!o_Trig_Valid && k < 30) begin
            cyc(1);
            k++;
        end
        if (!o_Trig_Valid) chk_val("valid_timeout", 32'(o_Trig_Valid), 32'd1);
    endtask

    // Wait for an offer, check its id, ack it, then pulse Read_Done right after
    task automatic take_trig(input logic [3:0] exp_id, input logic exp_more);
        wait_valid();
        chk_val("trig_id", 32'(o_Trig_Id), 32'(exp_id));
        i_Trig_Ack = 1'b1;
        cyc(1);
        i_Trig_Ack  = 1'b0;
        i_Read_Done = 1'b1;
        chk_val("valid_in_busy", 32'(o_Trig_Valid), 32'd0);
        cyc(1);
        i_Read_Done = 1'b0;
        chk_val("valid_after_done", 32'(o_Trig_Valid), 32'(exp_more));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset release, idle inputs
        do_reset();
        cyc(10);
        chk_val("rst_valid", 32'(o_Trig_Valid), 32'd0);
        chk_val("rst_id", 32'(o_Trig_Id), 32'd0);
        chk_val("rst_pending", 32'(o_Pending), 32'd0);
        chk_val("rst_full", 32'(o_L1_Reg_Full), 32'd0);
        chk_val("rst_error", 32'(o_Error), 32'd0);
        chk_val("rst_seq", 32'(o_Seq_Error), 32'd0);

        // 2: single trigger
        l1_inc();
        cyc(1);
        chk_val("t2_pend_lat1", 32'(o_Pending), 32'd0);
        cyc(1);
        chk_val("t2_pending", 32'(o_Pending), 32'd1);
        chk_val("t2_valid", 32'(o_Trig_Valid), 32'd1);
        take_trig(4'd1, 1'b0);
        cyc(1);
        chk_val("t2_pend_drained", 32'(o_Pending), 32'd0);
        chk_val("t2_valid_idle", 32'(o_Trig_Valid), 32'd0);

        // 3: fill to full without acking, then two more, then drain three
        repeat (12) begin
            l1_inc();
            cyc(1);
        end
        cyc(2);
        chk_val("t3_pend12", 32'(o_Pending), 32'd12);
        chk_val("t3_full12", 32'(o_L1_Reg_Full), 32'd0);
        l1_inc();
        cyc(1);
        chk_val("t3_full_lat", 32'(o_L1_Reg_Full), 32'd0);
        cyc(1);
        chk_val("t3_pend13", 32'(o_Pending), 32'd13);
        chk_val("t3_full13", 32'(o_L1_Reg_Full), 32'd1);
        l1_inc();
        cyc(1);
        l1_inc();
        cyc(2);
        chk_val("t3_pend15", 32'(o_Pending), 32'd15);
        chk_val("t3_full15", 32'(o_L1_Reg_Full), 32'd1);
        chk_val("t3_offer_id", 32'(o_Trig_Id), 32'd2);
        take_trig(4'd2, 1'b1);
        take_trig(4'd3, 1'b1);
        take_trig(4'd4, 1'b1);
        cyc(2);
        chk_val("t3_pend_after", 32'(o_Pending), 32'd12);
        chk_val("t3_full_after", 32'(o_L1_Reg_Full), 32'd0);
        chk_val("t3_seq", 32'(o_Seq_Error), 32'd0);

        // 4: twenty triggers with back-to-back Read_Done, pointer wraps
        do_reset();
        repeat (10) begin
            l1_inc();
            cyc(1);
        end
        for (int k = 0; k < 20; k++) begin
            if (k < 10) l1_inc();
            take_trig(4'((k + 1) % 16), (k < 19) ? 1'b1 : 1'b0);
        end
        cyc(2);
        chk_val("t4_pend_end", 32'(o_Pending), 32'd0);
        chk_val("t4_seq", 32'(o_Seq_Error), 32'd0);
        chk_val("t4_error", 32'(o_Error), 32'd0);

        // 5: single-copy upset on rd1 bit0 while trigger 1 is offered
        do_reset();
        l1_inc();
        wait_valid();
        chk_val("t5_err_before", 32'(o_Error), 32'd0);
        force dut.r_rd1 = 4'b0001;
        cyc(1);
        release dut.r_rd1;
        chk_val("t5_err_set", 32'(o_Error), 32'd1);
        chk_val("t5_id_held", 32'(o_Trig_Id), 32'd1);
        cyc(1);
        chk_val("t5_err_healed", 32'(o_Error), 32'd0);
        chk_val("t5_id_after", 32'(o_Trig_Id), 32'd1);
        chk_val("t5_pend", 32'(o_Pending), 32'd1);
        take_trig(4'd1, 1'b0);

        // 6: Ack in IDLE ignored, Read_Done in IDLE flags
        cyc(2);
        i_Trig_Ack = 1'b1;
        cyc(1);
        i_Trig_Ack = 1'b0;
        chk_val("t6_ack_idle_valid", 32'(o_Trig_Valid), 32'd0);
        chk_val("t6_ack_idle_seq", 32'(o_Seq_Error), 32'd0);
        i_Read_Done = 1'b1;
        cyc(1);
        i_Read_Done = 1'b0;
        chk_val("t6_done_idle_seq", 32'(o_Seq_Error), 32'd1);
        cyc(3);
        chk_val("t6_ptr_kept", 32'(o_Pending), 32'd0);
        chk_val("t6_seq_sticky", 32'(o_Seq_Error), 32'd1);
        do_reset();
        chk_val("t6_seq_cleared", 32'(o_Seq_Error), 32'd0);

        // 6b: illegal Gray jump 0000 -> 0011 (binary 2)
        i_L1In = 4'b0011;
        cyc(1);
        chk_val("t6_gray_seq", 32'(o_Seq_Error), 32'd1);
        cyc(3);
        chk_val("t6_gray_sticky", 32'(o_Seq_Error), 32'd1);
        chk_val("t6_gray_pend", 32'(o_Pending), 32'd2);
        chk_val("t6_gray_id", 32'(o_Trig_Id), 32'd1);
        do_reset();
        chk_val("t6_gray_cleared", 32'(o_Seq_Error), 32'd0);

        // 6c: Ack and Done together in OFFER
        l1_inc();
        wait_valid();
        i_Trig_Ack  = 1'b1;
        i_Read_Done = 1'b1;
        cyc(1);
        i_Trig_Ack  = 1'b0;
        i_Read_Done = 1'b0;
        chk_val("t6_ackdone_seq", 32'(o_Seq_Error), 32'd1);
        chk_val("t6_ackdone_busy", 32'(o_Trig_Valid), 32'd0);
        cyc(2);
        chk_val("t6_ackdone_pend", 32'(o_Pending), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
